// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the multi-cycle RV32E sequencer: state encoding and writeback-source codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro used by the sequencer: CORE_SEQ_PERF_EN (performance counters).
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } seq_state_e;

    // Writeback source select as decoded by the control unit.
    localparam logic [1:0] RD_DATA_SEL_ALU = 2'd0;
    localparam logic [1:0] RD_DATA_SEL_PC4 = 2'd1;
    localparam logic [1:0] RD_DATA_SEL_LSU = 2'd2;
    localparam logic [1:0] RD_DATA_SEL_IMM = 2'd3;

    // An instruction needs the MEMORY phase if it stores or loads.
    function automatic logic needs_mem(input logic lsu_we, input logic [1:0] rd_data_sel);
        return lsu_we | (rd_data_sel == RD_DATA_SEL_LSU);
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Bundles the sequencer's control-unit inputs, memory handshakes, write strobes and trace outputs.
// Latency: n/a (wiring only).
// Backpressure: imem_ack / lsu_ack hold the sequencer in FETCH / MEMORY until asserted.
// Ports (master = sequencer side):
//   in : regfile_we, lsu_we, rd_data_sel[1:0], imem_ack, lsu_ack, halt_req
//   out: imem_req, ir_we, lsu_req, pc_we, regfile_we_o, halted, state[2:0],
//        cycle_count[31:0], instret_count[31:0]
interface core_sequencer_if;
    logic        regfile_we;
    logic        lsu_we;
    logic [1:0]  rd_data_sel;
    logic        imem_ack;
    logic        lsu_ack;
    logic        halt_req;
    logic        imem_req;
    logic        ir_we;
    logic        lsu_req;
    logic        pc_we;
    logic        regfile_we_o;
    logic        halted;
    logic [2:0]  state;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;

    modport master (
        input  regfile_we, lsu_we, rd_data_sel, imem_ack, lsu_ack, halt_req,
        output imem_req, ir_we, lsu_req, pc_we, regfile_we_o, halted, state,
               cycle_count, instret_count
    );

    modport slave (
        output regfile_we, lsu_we, rd_data_sel, imem_ack, lsu_ack, halt_req,
        input  imem_req, ir_we, lsu_req, pc_we, regfile_we_o, halted, state,
               cycle_count, instret_count
    );
endinterface

// File: rtl/core_perf_counters.sv
// Free-running cycle and retired-instruction counters, wrapping at 2^32.
// Latency: count visible the cycle after the increment is sampled.
// Backpressure: none; increments are single-cycle enables.
// Ports: clk, rst_n, cyc_inc, ret_inc -> cycle_count[31:0], instret_count[31:0]
module core_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cyc_inc,
    input  logic        ret_inc,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
);
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] ret_q, ret_d;

    // Plain modular add: rolls over from 0xFFFF_FFFF to 0.
    always_comb begin
        cyc_d = cyc_q + {31'd0, cyc_inc};
        ret_d = ret_q + {31'd0, ret_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign cycle_count   = cyc_q;
    assign instret_count = ret_q;
endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer: FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK, with debug HALT at boundaries.
// Latency: 4 cycles ALU/branch, 5 cycles load/store, +1 per imem/lsu wait cycle.
// Backpressure: waits in FETCH for imem_ack and in MEMORY for lsu_ack; requests are never abandoned.
// Ports: clk, rst_n (async, active-low), bus (core_sequencer_if.master).
// Parameter HALT_ON_RESET: leave reset parked in HALT instead of FETCH.
// Macro CORE_SEQ_PERF_EN: enables cycle/instret counters; otherwise both read 0 and no flops exist.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic HALT_ON_RESET = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    core_sequencer_if.master bus
);
    localparam seq_state_e RESET_STATE = HALT_ON_RESET ? HALT : FETCH;

    seq_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Acks are only looked at in the state that issued the request, so a stray
    // or simultaneous ack for the other port has no effect. halt_req is only
    // sampled at the instruction boundary (WRITEBACK) and in HALT itself.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:     if (bus.imem_ack) state_d = DECODE;
            DECODE:    state_d = EXECUTE;
            EXECUTE:   state_d = needs_mem(bus.lsu_we, bus.rd_data_sel) ? MEMORY : WRITEBACK;
            MEMORY:    if (bus.lsu_ack) state_d = WRITEBACK;
            WRITEBACK: state_d = bus.halt_req ? HALT : FETCH;
            HALT:      if (!bus.halt_req) state_d = FETCH;
            default:   state_d = FETCH;
        endcase
    end

    // Strobes are decoded from state, and additionally gated by rst_n so that
    // asserting reset drops every request and write strobe immediately rather
    // than leaving imem_req high while the state register sits at FETCH.
    always_comb begin
        bus.imem_req     = 1'b0;
        bus.ir_we        = 1'b0;
        bus.lsu_req      = 1'b0;
        bus.pc_we        = 1'b0;
        bus.regfile_we_o = 1'b0;
        bus.halted       = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.ir_we    = bus.imem_ack;
                end
                MEMORY:    bus.lsu_req = 1'b1;
                WRITEBACK: begin
                    bus.pc_we        = 1'b1;
                    bus.regfile_we_o = bus.regfile_we;
                end
                HALT:      bus.halted = 1'b1;
                default:   ;
            endcase
        end
    end

    assign bus.state = state_q;

`ifdef CORE_SEQ_PERF_EN
    core_perf_counters u_perf (
        .clk           (clk),
        .rst_n         (rst_n),
        .cyc_inc       (1'b1),
        .ret_inc       (state_q == WRITEBACK),
        .cycle_count   (bus.cycle_count),
        .instret_count (bus.instret_count)
    );
`else
    assign bus.cycle_count   = '0;
    assign bus.instret_count = '0;
`endif

endmodule
